// File: rtl/uart_psram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_psram_bridge
// Description : Framed UART command bridge to the PSRAM controller. It parses
//               opcode/address/write-data frames, runs single or burst word
//               accesses, and returns read data over UART TX. An inter-byte
//               timeout drops stalled frames.
//               Optional feature macro: UART_PSRAM_BRIDGE_STATUS_EN adds a
//               trailing status byte (0x00 OK, 0xE1 bad opcode, 0xE2 timeout)
//               after every command.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_psram_bridge #(
    parameter int ADDR_BYTES = 3,
    parameter int DATA_BYTES = 2,
    parameter int MAX_BURST  = 4,
    parameter int TIMEOUT_US = 1000
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    tick_1us,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    rx_read,
    input  logic                    tx_busy,
    output logic                    tx_write,
    output logic [7:0]              tx_data,
    output logic                    mem_stb,
    output logic                    mem_we,
    output logic [8*ADDR_BYTES-1:0] mem_addr,
    output logic [8*DATA_BYTES-1:0] mem_wdat,
    input  logic                    mem_busy,
    input  logic [8*DATA_BYTES-1:0] mem_rdat,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int C_AW = 8 * ADDR_BYTES;
    localparam int C_DW = 8 * DATA_BYTES;
    localparam int C_TW = $clog2(TIMEOUT_US + 1);

    localparam logic [3:0]      C_ADDR_LAST = 4'(ADDR_BYTES - 1);
    localparam logic [3:0]      C_DATA_LAST = 4'(DATA_BYTES - 1);
    localparam logic [3:0]      C_MAX_BURST = 4'(MAX_BURST);
    localparam logic [C_TW-1:0] C_TMO_LIMIT = C_TW'(TIMEOUT_US);
    localparam logic [C_AW-1:0] C_ADDR_ONE  = C_AW'(1);

    localparam logic [2:0] C_ST_IDLE     = 3'd0;
    localparam logic [2:0] C_ST_ADDR     = 3'd1;
    localparam logic [2:0] C_ST_WDATA    = 3'd2;
    localparam logic [2:0] C_ST_MEM_REQ  = 3'd3;
    localparam logic [2:0] C_ST_MEM_WAIT = 3'd4;
    localparam logic [2:0] C_ST_MEM_DONE = 3'd5;
    localparam logic [2:0] C_ST_TX_DATA  = 3'd6;
`ifdef UART_PSRAM_BRIDGE_STATUS_EN
    localparam logic [2:0] C_ST_TX_STATUS = 3'd7;
    // Every command, good or bad, finishes by reporting its status.
    localparam logic [2:0] C_ST_END       = C_ST_TX_STATUS;
    localparam logic [7:0] C_STAT_OK      = 8'h00;
    localparam logic [7:0] C_STAT_BAD     = 8'hE1;
    localparam logic [7:0] C_STAT_TMO     = 8'hE2;
`else
    localparam logic [2:0] C_ST_END       = C_ST_IDLE;
`endif

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic            r_is_write;
    logic [3:0]      r_words_left;
    logic [3:0]      r_byte_cnt;
    logic [C_AW-1:0] r_addr;
    logic [C_DW-1:0] r_wdat;
    logic [C_DW-1:0] r_rdat;
    logic [C_TW-1:0] r_tmo_cnt;
    logic            r_err_timeout;
    logic            r_tx_gap;
`ifdef UART_PSRAM_BRIDGE_STATUS_EN
    logic [7:0]      r_status;
`endif

    logic            w_collecting;
    logic            w_timeout;
    logic [3:0]      w_op_n;
    logic            w_op_ok;
    logic            w_tx_slot;

    assign w_collecting = (r_state == C_ST_ADDR) || (r_state == C_ST_WDATA);
    // The timeout takes priority over a byte arriving in the same cycle.
    assign w_timeout    = w_collecting && (r_tmo_cnt == C_TMO_LIMIT);
    assign w_op_n       = {1'b0, rx_data[2:0]} + 4'd1;
    assign w_op_ok      = (rx_data[6:3] == 4'd0) && (w_op_n <= C_MAX_BURST);
    // One idle cycle after each strobe lets the UART raise tx_busy.
    assign w_tx_slot    = !tx_busy && !r_tx_gap;

    assign mem_we      = r_is_write;
    assign mem_addr    = r_addr;
    assign mem_wdat    = r_wdat;
    assign err_timeout = r_err_timeout;

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode for frame parsing, memory access and TX streaming.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (rx_read) begin
                    w_state_nxt = w_op_ok ? C_ST_ADDR : C_ST_END;
                end
            end
            C_ST_ADDR: begin
                if (w_timeout) begin
                    w_state_nxt = C_ST_END;
                end else if (rx_read && (r_byte_cnt == C_ADDR_LAST)) begin
                    w_state_nxt = r_is_write ? C_ST_WDATA : C_ST_MEM_REQ;
                end
            end
            C_ST_WDATA: begin
                if (w_timeout) begin
                    w_state_nxt = C_ST_END;
                end else if (rx_read && (r_byte_cnt == C_DATA_LAST)) begin
                    w_state_nxt = C_ST_MEM_REQ;
                end
            end
            C_ST_MEM_REQ:  w_state_nxt = C_ST_MEM_WAIT;
            C_ST_MEM_WAIT: w_state_nxt = C_ST_MEM_DONE;
            C_ST_MEM_DONE: begin
                if (!mem_busy) begin
                    if (!r_is_write) begin
                        w_state_nxt = C_ST_TX_DATA;
                    end else if (r_words_left == 4'd1) begin
                        w_state_nxt = C_ST_END;
                    end else begin
                        w_state_nxt = C_ST_WDATA;
                    end
                end
            end
            C_ST_TX_DATA: begin
                // Word count was already decremented when the access finished.
                if (tx_write && (r_byte_cnt == C_DATA_LAST)) begin
                    w_state_nxt = (r_words_left == 4'd0) ? C_ST_END : C_ST_MEM_REQ;
                end
            end
`ifdef UART_PSRAM_BRIDGE_STATUS_EN
            C_ST_TX_STATUS: begin
                if (tx_write) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = C_ST_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        rx_read  = 1'b0;
        tx_write = 1'b0;
        tx_data  = 8'h00;
        mem_stb  = (r_state == C_ST_MEM_REQ);
        busy     = (r_state != C_ST_IDLE);
        if ((r_state == C_ST_IDLE) || (w_collecting && !w_timeout)) begin
            rx_read = rx_valid;
        end
        if (r_state == C_ST_TX_DATA) begin
            tx_write = w_tx_slot;
            tx_data  = w_tx_slot ? r_rdat[C_DW-1 -: 8] : 8'h00;
        end
`ifdef UART_PSRAM_BRIDGE_STATUS_EN
        if (r_state == C_ST_TX_STATUS) begin
            tx_write = w_tx_slot;
            tx_data  = w_tx_slot ? r_status : 8'h00;
        end
`endif
    end

    // Frame datapath: opcode fields, address/data shift registers, word count.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_is_write    <= 1'b0;
            r_words_left  <= 4'd0;
            r_byte_cnt    <= 4'd0;
            r_addr        <= '0;
            r_wdat        <= '0;
            r_rdat        <= '0;
            r_err_timeout <= 1'b0;
`ifdef UART_PSRAM_BRIDGE_STATUS_EN
            r_status      <= 8'h00;
`endif
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (rx_read && w_op_ok) begin
                        r_is_write    <= rx_data[7];
                        r_words_left  <= w_op_n;
                        r_byte_cnt    <= 4'd0;
                        r_err_timeout <= 1'b0;
                    end
`ifdef UART_PSRAM_BRIDGE_STATUS_EN
                    if (rx_read) begin
                        r_status <= w_op_ok ? C_STAT_OK : C_STAT_BAD;
                    end
`endif
                end
                C_ST_ADDR: begin
                    if (rx_read) begin
                        r_addr     <= (r_addr << 8) | C_AW'(rx_data);
                        r_byte_cnt <= (r_byte_cnt == C_ADDR_LAST) ? 4'd0 : r_byte_cnt + 4'd1;
                    end
                end
                C_ST_WDATA: begin
                    if (rx_read) begin
                        r_wdat     <= (r_wdat << 8) | C_DW'(rx_data);
                        r_byte_cnt <= (r_byte_cnt == C_DATA_LAST) ? 4'd0 : r_byte_cnt + 4'd1;
                    end
                end
                C_ST_MEM_DONE: begin
                    if (!mem_busy) begin
                        r_addr       <= r_addr + C_ADDR_ONE;
                        r_words_left <= r_words_left - 4'd1;
                        r_byte_cnt   <= 4'd0;
                        if (!r_is_write) begin
                            r_rdat <= mem_rdat;
                        end
                    end
                end
                C_ST_TX_DATA: begin
                    if (tx_write) begin
                        r_rdat     <= r_rdat << 8;
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
`ifdef UART_PSRAM_BRIDGE_STATUS_EN
                r_status      <= C_STAT_TMO;
`endif
            end
        end
    end

    // Inter-byte timeout: counts microseconds while collecting, cleared per byte.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_tmo_cnt <= '0;
        end else if (!w_collecting || rx_read) begin
            r_tmo_cnt <= '0;
        end else if (tick_1us && (r_tmo_cnt != C_TMO_LIMIT)) begin
            r_tmo_cnt <= r_tmo_cnt + C_TW'(1);
        end
    end

    // Remember the previous TX strobe to force a one-cycle gap.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_tx_gap <= 1'b0;
        end else begin
            r_tx_gap <= tx_write;
        end
    end

endmodule
`default_nettype wire
